pwm_clock_divider_mc: RTL and testbench

//  Multi-channel, parametrised successor to the single-channel PWM clock divider. Each channel generates
//  a registered, glitch-free divided clock and a one-cycle period tick from a single system clock.
//  A new divide value takes effect only at a period boundary. A common sync input phase-aligns all channels.

---
 rtl/pwm_clock_divider_mc_pkg.sv | 40 ++++
 rtl/pwm_clock_divider_mc_if.sv | 30 +++
 rtl/pwm_clock_divider_mc_channel.sv | 62 ++++++
 rtl/pwm_clock_divider_mc.sv | 41 ++++
 tb/tb_pwm_clock_divider_mc.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pwm_clock_divider_mc_pkg.sv
// Shared types and helpers for the multi-channel PWM clock divider.
//   cnt_w()      : counter width derived from the divide-value width
//   last_count() : final count of a period for a given divide value and mode
//   high_limit() : number of leading high cycles in a period
//   ch_state_t   : per-channel state, sized for the widest supported divide value
// Optional feature macro: PWM_CLKDIV_FINE_EN (odd-ratio fine mode).
package pwm_clkdiv_pkg;

  localparam int unsigned MaxDivW = 16;
  localparam int unsigned MaxCntW = MaxDivW + 1;

  typedef logic [MaxDivW-1:0] div_t;
  typedef logic [MaxCntW-1:0] cnt_t;

  typedef enum logic {StIdle, StRun} ch_fsm_e;

  typedef struct packed {
    ch_fsm_e state;
    cnt_t    cnt;
    div_t    d_act;
    logic    fine;
    logic    clk_out;
    logic    tick;
  } ch_state_t;

  function automatic int unsigned cnt_w(input int unsigned div_w);
    return div_w + 1;
  endfunction

  // Normal mode: 2*d+1. Fine mode: d.
  function automatic cnt_t last_count(input div_t d, input logic fine);
    return fine ? cnt_t'(d) : {d, 1'b1};
  endfunction

  // Normal mode: d+1 high cycles. Fine mode: ceil((d+1)/2) high cycles.
  function automatic cnt_t high_limit(input div_t d, input logic fine);
    return fine ? cnt_t'(d >> 1) + cnt_t'(1) : cnt_t'(d) + cnt_t'(1);
  endfunction

endpackage

// File: rtl/pwm_clock_divider_mc_if.sv
// Control/status bundle of the multi-channel PWM clock divider.
//   enable, div_value, sync_req, fine_mode : register-file side -> divider
//   clock_out, tick, running               : divider -> compare/output stages
// fine_mode exists only when PWM_CLKDIV_FINE_EN is defined.
interface pwm_clock_divider_mc_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8
);
  logic [NUM_CH-1:0]       enable;
  logic [NUM_CH*DIV_W-1:0] div_value;
  logic                    sync_req;
`ifdef PWM_CLKDIV_FINE_EN
  logic [NUM_CH-1:0]       fine_mode;
`endif
  logic [NUM_CH-1:0]       clock_out;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       running;

`ifdef PWM_CLKDIV_FINE_EN
  modport master (output enable, div_value, sync_req, fine_mode,
                  input  clock_out, tick, running);
  modport slave  (input  enable, div_value, sync_req, fine_mode,
                  output clock_out, tick, running);
`else
  modport master (output enable, div_value, sync_req,
                  input  clock_out, tick, running);
  modport slave  (input  enable, div_value, sync_req,
                  output clock_out, tick, running);
`endif
endinterface

// File: rtl/pwm_clock_divider_mc_channel.sv
// One divider channel: registered divided clock, one-cycle period tick, running flag.
//   clock_in, reset : system clock, synchronous active-high reset
//   enable          : run enable (drop aborts the period at the next edge)
//   div_value       : divide value D, sampled only at start/sync/wrap
//   sync_req        : restart in phase if running
//   fine_mode       : odd-ratio mode select, sampled with D (tied low unless PWM_CLKDIV_FINE_EN)
//   clock_out, tick, running : registered outputs
module pwm_clkdiv_channel
  import pwm_clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [DIV_W-1:0] div_value,
  input  logic             sync_req,
  input  logic             fine_mode,
  output logic             clock_out,
  output logic             tick,
  output logic             running
);

  localparam int unsigned CntW = cnt_w(DIV_W);

  ch_state_t       st_q;
  logic [CntW-1:0] cnt_inc;
  div_t            div_ext;

  // Count never exceeds 2*(2^DIV_W-1)+1, so CntW bits never overflow.
  assign cnt_inc = CntW'(st_q.cnt + cnt_t'(1));
  assign div_ext = div_t'(div_value);

  always_ff @(posedge clock_in) begin
    if (reset) begin
      st_q <= '0;
    end else if (!enable) begin
      st_q.state   <= StIdle;
      st_q.cnt     <= '0;
      st_q.clk_out <= 1'b0;
      st_q.tick    <= 1'b0;
    end else if (st_q.state == StIdle || sync_req ||
                 st_q.cnt == last_count(st_q.d_act, st_q.fine)) begin
      // Start, sync and wrap all open a fresh period and load the shadow D.
      st_q.state   <= StRun;
      st_q.cnt     <= '0;
      st_q.d_act   <= div_ext;
      st_q.fine    <= fine_mode;
      st_q.clk_out <= 1'b1;
      st_q.tick    <= 1'b1;
    end else begin
      st_q.cnt     <= cnt_t'(cnt_inc);
      st_q.clk_out <= cnt_t'(cnt_inc) < high_limit(st_q.d_act, st_q.fine);
      st_q.tick    <= 1'b0;
    end
  end

  assign clock_out = st_q.clk_out;
  assign tick      = st_q.tick;
  assign running   = (st_q.state == StRun);

endmodule

// File: rtl/pwm_clock_divider_mc.sv
// Multi-channel PWM clock divider: NUM_CH independent channels sharing clock, reset and sync_req.
//   clock_in : system clock
//   reset    : synchronous active-high reset
//   bus      : slave side of pwm_clock_divider_mc_if (enable, div_value, sync_req,
//              fine_mode -> clock_out, tick, running)
// Optional feature macro: PWM_CLKDIV_FINE_EN adds per-channel fine_mode.
module pwm_clock_divider_mc
  import pwm_clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W  = 8
) (
  input logic                   clock_in,
  input logic                   reset,
  pwm_clock_divider_mc_if.slave bus
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic fine;
`ifdef PWM_CLKDIV_FINE_EN
    assign fine = bus.fine_mode[gi];
`else
    assign fine = 1'b0;
`endif

    pwm_clkdiv_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clock_in  (clock_in),
      .reset     (reset),
      .enable    (bus.enable[gi]),
      .div_value (bus.div_value[gi*DIV_W +: DIV_W]),
      .sync_req  (bus.sync_req),
      .fine_mode (fine),
      .clock_out (bus.clock_out[gi]),
      .tick      (bus.tick[gi]),
      .running   (bus.running[gi])
    );
  end

endmodule

// File: tb/tb_pwm_clock_divider_mc.sv
module tb_pwm_clock_divider_mc;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DIV_W  = 8;

  logic clock_in = 1'b0;
  logic reset    = 1'b1;

  pwm_clock_divider_mc_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  pwm_clock_divider_mc #(
    .NUM_CH (NUM_CH),
    .DIV_W  (DIV_W)
  ) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  clk;
    logic [3:0]  tck;
    logic [3:0]  run;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clock_in) cyc <= cyc + 1;

  // Monitor: compare every expectation scheduled for the edge just taken.
  always @(negedge clock_in) begin : monitor
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      checks++;
      if (e.cyc != cyc || bus.clock_out !== e.clk || bus.tick !== e.tck ||
          bus.running !== e.run) begin
        errors++;
        $display("FAIL cycle %0d (sched %0d): clock_out=%b tick=%b running=%b, required %b %b %b",
                 cyc, e.cyc, bus.clock_out, bus.tick, bus.running, e.clk, e.tck, e.run);
      end
    end
  end

  // Push the outputs expected after the next edge, then advance one cycle.
  task automatic step(input logic [3:0] c, input logic [3:0] t, input logic [3:0] r);
    exp_t e;
    e.cyc = cyc + 1;
    e.clk = c;
    e.tck = t;
    e.run = r;
    sb_q.push_back(e);
    @(posedge clock_in);
    #1;
  endtask

  task automatic set_div(input int ch, input int d);
    bus.div_value[ch*DIV_W +: DIV_W] = DIV_W'(d);
  endtask

  // Single-channel (ch0) pattern, first cycle in the MSB.
  task automatic run_ch0(input int n, input logic [31:0] c, input logic [31:0] t);
    for (int i = 0; i < n; i++) begin
      step({3'b000, c[n-1-i]}, {3'b000, t[n-1-i]}, 4'b0001);
    end
  endtask

  initial begin
    bus.enable    = '0;
    bus.div_value = '0;
    bus.sync_req  = 1'b0;
`ifdef PWM_CLKDIV_FINE_EN
    bus.fine_mode = '0;
`endif

    // Reset state
    step(4'b0, 4'b0, 4'b0);
    step(4'b0, 4'b0, 4'b0);
    reset = 1'b0;
    step(4'b0, 4'b0, 4'b0);

    // D=3: 4 high / 4 low, tick on first high cycle
    set_div(0, 3);
    bus.enable = 4'b0001;
    run_ch0(16, 32'b1111_0000_1111_0000, 32'b1000_0000_1000_0000);
    bus.enable = 4'b0000;
    step(4'b0, 4'b0, 4'b0);

    // D=0: divide by 2
    set_div(0, 0);
    bus.enable = 4'b0001;
    run_ch0(6, 32'b101010, 32'b101010);
    bus.enable = 4'b0000;
    step(4'b0, 4'b0, 4'b0);

    // D=255: period 512, 256 high
    set_div(0, 255);
    bus.enable = 4'b0001;
    for (int i = 0; i < 1024; i++) begin
      step({3'b000, (i % 512) < 256}, {3'b000, (i % 512) == 0}, 4'b0001);
    end
    bus.enable = 4'b0000;
    step(4'b0, 4'b0, 4'b0);

    // D change mid-period: current period stays 8, then periods of 4
    set_div(0, 3);
    bus.enable = 4'b0001;
    run_ch0(3, 32'b111, 32'b100);
    set_div(0, 1);
    run_ch0(13, 32'b10000_1100_1100, 32'b00000_1000_1000);
    bus.enable = 4'b0000;
    step(4'b0, 4'b0, 4'b0);

    // Two channels, sync pulse realigns both; ch2 idle
    set_div(0, 2);
    set_div(1, 5);
    set_div(2, 1);
    bus.enable = 4'b0011;
    step(4'b0011, 4'b0011, 4'b0011);
    step(4'b0011, 4'b0000, 4'b0011);
    step(4'b0011, 4'b0000, 4'b0011);
    step(4'b0010, 4'b0000, 4'b0011);
    bus.sync_req = 1'b1;
    step(4'b0011, 4'b0011, 4'b0011);
    bus.sync_req = 1'b0;
    step(4'b0011, 4'b0000, 4'b0011);
    bus.enable = 4'b0000;
    step(4'b0, 4'b0, 4'b0);

    // Enable drop at cnt=5, reset mid-period, re-enable
    set_div(0, 3);
    bus.enable = 4'b0001;
    run_ch0(6, 32'b111100, 32'b100000);
    bus.enable = 4'b0000;
    step(4'b0, 4'b0, 4'b0);
    bus.enable = 4'b0001;
    run_ch0(2, 32'b11, 32'b10);
    reset = 1'b1;
    step(4'b0, 4'b0, 4'b0);
    reset = 1'b0;
    run_ch0(6, 32'b111100, 32'b100000);
    bus.enable = 4'b0000;
    step(4'b0, 4'b0, 4'b0);

`ifdef PWM_CLKDIV_FINE_EN
    // Fine mode D=4: period 5, 3 high / 2 low; D=0: constant high, tick every cycle
    bus.fine_mode = 4'b0001;
    set_div(0, 4);
    bus.enable = 4'b0001;
    run_ch0(10, 32'b11100_11100, 32'b10000_10000);
    bus.enable = 4'b0000;
    step(4'b0, 4'b0, 4'b0);
    set_div(0, 0);
    bus.enable = 4'b0001;
    run_ch0(4, 32'b1111, 32'b1111);
    bus.enable = 4'b0000;
    step(4'b0, 4'b0, 4'b0);
`endif

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clock_in);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations pending, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
